// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a runtime-loadable pattern, overlap control and a match counter.
// Macro SEQ_DET_COUNT_EN enables the saturating match counter; without it match_count is tied to zero.
`default_nettype none

module seq_detector_param #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1010,
  parameter int                   COUNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           x,
  input  logic                           x_valid,
  input  logic                           overlap,
  input  logic                           load,
  input  logic [PATTERN_W-1:0]           pattern_in,
  input  logic                           cnt_clr,
  output logic                           y,
  output logic [$clog2(PATTERN_W+1)-1:0] fill,
  output logic [COUNT_W-1:0]             match_count
);

  localparam int                FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] C_FULL = FILL_W'(PATTERN_W);

  logic [PATTERN_W-1:0] r_pat,  w_pat_n;
  logic [PATTERN_W-1:0] r_hist, w_hist_n;
  logic [FILL_W-1:0]    r_fill, w_fill_n;
  logic                 r_y,    w_y_n;

  logic [PATTERN_W-1:0] w_hist_shift;
  logic [FILL_W-1:0]    w_fill_inc;
  logic                 w_hit;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= PATTERN_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else begin
      r_pat  <= w_pat_n;
      r_hist <= w_hist_n;
      r_fill <= w_fill_n;
      r_y    <= w_y_n;
    end
  end

  assign w_hist_shift = {r_hist[PATTERN_W-2:0], x};
  assign w_fill_inc   = (r_fill == C_FULL) ? C_FULL : r_fill + 1'b1;
  // A load drops the bit offered on the same edge, so it can never match.
  assign w_hit        = x_valid && !load && (w_fill_inc == C_FULL) && (w_hist_shift == r_pat);

  // Next-state logic
  always_comb begin
    w_pat_n  = r_pat;
    w_hist_n = r_hist;
    w_fill_n = r_fill;
    w_y_n    = 1'b0;
    if (load) begin
      w_pat_n  = pattern_in;
      w_hist_n = '0;
      w_fill_n = '0;
    end else if (x_valid) begin
      w_hist_n = w_hist_shift;
      w_y_n    = w_hit;
      if (w_hit)
        w_fill_n = overlap ? C_FULL : '0;
      else
        w_fill_n = w_fill_inc;
    end
  end

  // Outputs
  always_comb begin
    y    = r_y;
    fill = r_fill;
  end

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (w_hit && (r_cnt != {COUNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign match_count = r_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign match_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed-vector bench for seq_detector_param (W=4, reset pattern 1010, COUNT_W=2).
`default_nettype none

module tb_seq_detector_param;

`ifdef SEQ_DET_COUNT_EN
  localparam int C_CNT_EN = 1;
`else
  localparam int C_CNT_EN = 0;
`endif

  logic       clk;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       overlap;
  logic       load;
  logic [3:0] pattern_in;
  logic       cnt_clr;
  logic       y;
  logic [2:0] fill;
  logic [1:0] match_count;

  int n_cmp;
  int n_bad;

  seq_detector_param #(
    .PATTERN_W   (4),
    .PATTERN_RST (4'b1010),
    .COUNT_W     (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .overlap     (overlap),
    .load        (load),
    .pattern_in  (pattern_in),
    .cnt_clr     (cnt_clr),
    .y           (y),
    .fill        (fill),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected counter value for a given number of matches (saturates at 3, or 0 when disabled).
  function automatic logic [31:0] exp_cnt(input int n);
    if (C_CNT_EN == 0) return 0;
    return (n > 3) ? 3 : n;
  endfunction

  task automatic drive(input logic b, input logic v, input logic ld, input logic clr);
    @(negedge clk);
    x       = b;
    x_valid = v;
    load    = ld;
    cnt_clr = clr;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    load    = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Asynchronous reset pulse asserted between clock edges; outputs are checked while reset is low.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check({tag, "_rst_y"},    y,           0);
    check({tag, "_rst_fill"}, fill,        0);
    check({tag, "_rst_cnt"},  match_count, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Feed n bits (msb first) and compare y after every accepted bit.
  task automatic run_bits(input string tag, input logic [15:0] bits, input logic [15:0] yexp, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(bits[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("%s_y%0d", tag, n - i), y, yexp[i]);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    overlap    = 1'b1;
    load       = 1'b0;
    pattern_in = 4'b0000;
    cnt_clr    = 1'b0;

    #12;
    check("init_y",    y,           0);
    check("init_fill", fill,        0);
    check("init_cnt",  match_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Overlapping: 101010 matches after bits 4 and 6
    overlap = 1'b1;
    run_bits("ovl", 16'b101010, 16'b000101, 6);
    check("ovl_fill", fill,        4);
    check("ovl_cnt",  match_count, exp_cnt(2));

    // Idle edge: y drops, fill and history hold
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_y",    y,    0);
    check("idle_fill", fill, 4);

    // Non-overlapping: only one match, history restarts
    pulse_reset("t2");
    overlap = 1'b0;
    run_bits("novl", 16'b101010, 16'b000100, 6);
    check("novl_fill", fill,        2);
    check("novl_cnt",  match_count, exp_cnt(1));

    // Reset mid-stream discards 1,0,1: the following 0 must not complete 1010
    pulse_reset("t3a");
    overlap = 1'b1;
    run_bits("pre", 16'b101, 16'b000, 3);
    pulse_reset("t3b");
    run_bits("post", 16'b0100, 16'b0000, 4);
    run_bits("fresh", 16'b1010, 16'b0001, 4);
    check("fresh_cnt", match_count, exp_cnt(1));

    // Load 1100 with a coincident valid bit that must be dropped
    pattern_in = 4'b1100;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("load_y",    y,           0);
    check("load_fill", fill,        0);
    check("load_cnt",  match_count, exp_cnt(1));
    run_bits("ld", 16'b1100, 16'b0001, 4);
    run_bits("ldx", 16'b1010, 16'b0000, 4);
    check("ld_cnt", match_count, exp_cnt(2));

    // Counter saturation with COUNT_W=2: five non-overlapping matches
    pulse_reset("t5");
    overlap = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      run_bits($sformatf("sat%0d", k), 16'b1010, 16'b0001, 4);
      check($sformatf("sat%0d_cnt", k), match_count, exp_cnt(k));
    end

    // cnt_clr coincident with a match: counter clears, y still pulses
    run_bits("clr", 16'b101, 16'b000, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_y",   y,           1);
    check("clr_cnt", match_count, 0);
    run_bits("aclr", 16'b1010, 16'b0001, 4);
    check("aclr_cnt", match_count, exp_cnt(1));

    // Overlap switched mid-stream takes effect on the next accepted bit
    overlap = 1'b1;
    run_bits("sw", 16'b1010, 16'b0001, 4);
    check("sw_fill", fill, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4, meaning pattern length in bits (range 2..16).
REQ-002 SHALL have parameter PATTERN_RST, default 4'b1010, meaning the pattern loaded at reset (PATTERN_W bits).
REQ-003 SHALL have parameter COUNT_W, default 8, meaning match counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port x, input, 1 bit: serial data bit.
REQ-007 SHALL have port x_valid, input, 1 bit: x is sampled only when high.
REQ-008 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port load, input, 1 bit: load pattern_in as the new pattern.
REQ-010 SHALL have port pattern_in, input, PATTERN_W bits: new pattern value.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous match-counter clear.
REQ-012 SHALL have port y, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port fill, output, clog2(PATTERN_W+1) bits: number of valid history bits.
REQ-014 SHALL have port match_count, output, COUNT_W bits: saturating match count.

Function
REQ-015 SHALL hold internal registers pat[PATTERN_W-1:0], hist[PATTERN_W-1:0] and fill; x enters hist at the LSB, so the oldest bit sits at the MSB.
REQ-016 SHALL, on an edge with x_valid=1, form hist_n = {hist[W-2:0], x} and fill_n = min(fill+1, W).
REQ-017 SHALL declare a match when fill_n==W and hist_n==pat; y SHALL be 1 for exactly the cycle after that edge.
REQ-018 SHALL, on a match, set fill to W if overlap=1, or to 0 if overlap=0 (discarding history); with no match, fill <= fill_n.
REQ-019 SHALL set y to 0 on any edge with x_valid=0; on that edge hist and fill SHALL hold.
REQ-020 SHALL sample overlap on every edge; a change takes effect on the next accepted bit with no flush.
REQ-021 SHALL, when load=1, set pat <= pattern_in and hist, fill, y <= 0; load SHALL take priority over x_valid (the bit is dropped), and match_count SHALL be unaffected.
REQ-022 SHALL increment match_count by 1 per match and saturate at 2^COUNT_W-1.
REQ-023 SHALL, when cnt_clr=1, set match_count to 0; cnt_clr SHALL win over a simultaneous match, and y still pulses.
REQ-024 SHALL, when the history is full, make a match-to-y latency of exactly 1 cycle from the edge accepting the final pattern bit.

Reset
REQ-025 SHALL, on reset=0, immediately set pat=PATTERN_RST, hist=0, fill=0, y=0 and match_count=0, independent of clk.
REQ-026 SHALL release reset synchronously; the first accepted bit SHALL be on the first rising edge with reset=1 and x_valid=1.
REQ-027 SHALL, on reset mid-stream, discard partial history; no match SHALL use bits received before reset.

Configuration
REQ-028 SHALL, with macro SEQ_DET_COUNT_EN defined, implement match_count and cnt_clr as specified above.
REQ-029 SHALL, with SEQ_DET_COUNT_EN undefined, omit the counter logic, tie match_count to constant 0 and ignore cnt_clr; y, fill and pattern behaviour SHALL be unchanged.

Verification (W=4, pattern 1010, SEQ_DET_COUNT_EN defined unless stated)
REQ-030 SHALL cover overlap=1, bits 1,0,1,0,1,0 on consecutive edges -> y pulses after bits 4 and 6, match_count=2, fill=4.
REQ-031 SHALL cover overlap=0, same stream -> y pulses after bit 4 only, match_count=1, fill=2 at end.
REQ-032 SHALL cover bits 1,0,1, then reset=0 for 1 cycle, then 0,1,0 -> no pulse; a pulse follows only after a fresh 1,0,1,0.
REQ-033 SHALL cover load with pattern_in=1100, then bits 1,1,0,0 -> pulse after bit 4; bits 1,0,1,0 -> no pulse.
REQ-034 SHALL cover COUNT_W=2 with 5 matches -> match_count=3; cnt_clr coincident with a match -> match_count=0 and y=1.
REQ-035 SHALL cover SEQ_DET_COUNT_EN undefined with 3 matches -> y pulses 3 times, match_count stays 0.
